// File: rtl/bsg_chip_pkg.sv
// Shared types and chip-level defaults for the link reset sequencer.
// The optional alive-wait timeout is enabled by BSG_CHIP_LINK_SEQ_TIMEOUT_EN.
package bsg_chip_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IO_HOLD,
        S_IO_REL,
        S_DS_REL,
        S_CORE_REL,
        S_ALIVE,
        S_DONE,
        S_ERROR
    } bsg_chip_link_seq_state_e;

    localparam int link_seq_io_hold_gp = 16;
    localparam int link_seq_settle_gp  = 64;
    localparam int link_seq_timeout_gp = 4096;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bsg_chip_link_seq_timer.sv
// Loadable down-counter that times every sequencer step.
// Counts down to 1 and holds there; expire_o flags the final cycle of a step.
module bsg_chip_link_seq_timer #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic [width_p-1:0] val_i,
    output logic               expire_o
);

    logic [width_p-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= val_i;
        end else if (cnt_q > width_p'(1)) begin
            cnt_q <= cnt_q - width_p'(1);
        end
    end

    assign expire_o = (cnt_q == width_p'(1));

endmodule

// File: rtl/bsg_chip_link_reset_sequencer.sv
// Orders io, downstream and core reset release for a link group, then waits for all links alive.
// Define BSG_CHIP_LINK_SEQ_TIMEOUT_EN to bound the alive wait and enable S_ERROR.
module bsg_chip_link_reset_sequencer
    import bsg_chip_pkg::*;
#(
    parameter int num_links_p = 2,
    parameter int io_hold_p   = link_seq_io_hold_gp,
    parameter int settle_p    = link_seq_settle_gp,
    parameter int timeout_p   = link_seq_timeout_gp
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic [num_links_p-1:0]   link_alive_i,
    output logic [num_links_p-1:0]   io_reset_o,
    output logic [num_links_p-1:0]   downstream_reset_o,
    output logic                     core_reset_o,
    output logic                     link_enable_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o,
    output bsg_chip_link_seq_state_e state_o
);

    localparam int cnt_w_lp = $clog2(max3(io_hold_p, settle_p, timeout_p) + 1);

    bsg_chip_link_seq_state_e state_q, state_n;
    logic                     load;
    logic [cnt_w_lp-1:0]      load_val;
    logic                     expire;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:     if (start_i) state_n = S_IO_HOLD;
            S_IO_HOLD:  if (expire) state_n = S_IO_REL;
            S_IO_REL:   if (expire) state_n = S_DS_REL;
            S_DS_REL:   if (expire) state_n = S_CORE_REL;
            S_CORE_REL: if (expire) state_n = S_ALIVE;
            S_ALIVE: begin
                if (&link_alive_i) begin
                    state_n = S_DONE;
                end
`ifdef BSG_CHIP_LINK_SEQ_TIMEOUT_EN
                else if (expire) begin
                    state_n = S_ERROR;
                end
`endif
            end
            S_DONE:     if (start_i) state_n = S_IO_HOLD;
            S_ERROR:    if (start_i) state_n = S_IO_HOLD;
            default:    state_n = S_IDLE;
        endcase
    end

    // The timer is reloaded on every state entry with the length of the state being entered.
    always_comb begin
        load     = (state_n != state_q);
        load_val = '0;
        case (state_n)
            S_IO_HOLD:  load_val = cnt_w_lp'(io_hold_p);
            S_IO_REL,
            S_DS_REL,
            S_CORE_REL: load_val = cnt_w_lp'(settle_p);
`ifdef BSG_CHIP_LINK_SEQ_TIMEOUT_EN
            S_ALIVE:    load_val = cnt_w_lp'(timeout_p);
`endif
            default:    load_val = '0;
        endcase
    end

    bsg_chip_link_seq_timer #(
        .width_p (cnt_w_lp)
    ) timer (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .load_i   (load),
        .val_i    (load_val),
        .expire_o (expire)
    );

    logic io_rst, ds_rst, core_rst;

    always_comb begin
        io_rst   = (state_q == S_IDLE) || (state_q == S_IO_HOLD) || (state_q == S_ERROR);
        ds_rst   = io_rst || (state_q == S_IO_REL);
        core_rst = ds_rst || (state_q == S_DS_REL);
    end

    assign io_reset_o         = {num_links_p{io_rst}};
    assign downstream_reset_o = {num_links_p{ds_rst}};
    assign core_reset_o       = core_rst;
    assign link_enable_o      = (state_q == S_DONE);
    assign done_o             = (state_q == S_DONE);
    assign busy_o             = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
`ifdef BSG_CHIP_LINK_SEQ_TIMEOUT_EN
    assign error_o            = (state_q == S_ERROR);
`else
    assign error_o            = 1'b0;
`endif
    assign state_o            = state_q;

endmodule

// File: tb/tb_bsg_chip_link_reset_sequencer.sv
// Scoreboard bench: each driven cycle pushes its expected output vector, a negedge monitor pops and compares.
// Output vector layout: {io_reset[1:0], downstream_reset[1:0], core_reset, link_enable, busy, done, error}.
module tb_bsg_chip_link_reset_sequencer;
    import bsg_chip_pkg::*;

    localparam logic [8:0] P_IDLE = 9'b11_11_1_0_0_0_0;
    localparam logic [8:0] P_HOLD = 9'b11_11_1_0_1_0_0;
    localparam logic [8:0] P_IOR  = 9'b00_11_1_0_1_0_0;
    localparam logic [8:0] P_DSR  = 9'b00_00_1_0_1_0_0;
    localparam logic [8:0] P_CORE = 9'b00_00_0_0_1_0_0;
    localparam logic [8:0] P_DONE = 9'b00_00_0_1_0_1_0;
    localparam logic [8:0] P_ERR  = 9'b11_11_1_0_0_0_1;
    localparam int NEVER = 9999;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_i = 1'b1;
    logic       start_i = 1'b0;
    logic [1:0] link_alive = 2'b00;
    logic [1:0] io_reset, ds_reset;
    logic       core_reset, link_enable, busy, done, error;
    bsg_chip_link_seq_state_e state;

    bsg_chip_link_reset_sequencer #(
        .num_links_p (2),
        .io_hold_p   (4),
        .settle_p    (8),
        .timeout_p   (32)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .start_i            (start_i),
        .link_alive_i       (link_alive),
        .io_reset_o         (io_reset),
        .downstream_reset_o (ds_reset),
        .core_reset_o       (core_reset),
        .link_enable_o      (link_enable),
        .busy_o             (busy),
        .done_o             (done),
        .error_o            (error),
        .state_o            (state)
    );

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];
    int         tag_q[$];
    wire [8:0]  act = {io_reset, ds_reset, core_reset, link_enable, busy, done, error};

    // Expected outputs for a sequence started at cycle s that reaches S_DONE at cycle d.
    function automatic logic [8:0] phase(input int c, input int s, input int d);
        int o;
        o = c - s;
        if (o <= 0)  return P_IDLE;
        if (o <= 4)  return P_HOLD;
        if (o <= 12) return P_IOR;
        if (o <= 20) return P_DSR;
        if (c >= d)  return P_DONE;
        return P_CORE;
    endfunction

    task automatic step(input logic rs, input logic st, input logic [1:0] al,
                        input logic [8:0] e, input int tag);
        @(posedge clk);
        #1;
        reset_i    = rs;
        start_i    = st;
        link_alive = al;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        int         t;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL outputs scen/cycle %0d: got %b expected %b", t, act, e);
            end
            checks++;
            if (($countones({busy, done, error}) > 1) ||
                (io_reset != 2'b00 && io_reset != 2'b11) ||
                (ds_reset != 2'b00 && ds_reset != 2'b11) ||
                (!core_reset && ds_reset != 2'b00) ||
                (ds_reset != 2'b11 && io_reset != 2'b00)) begin
                errors++;
                $display("FAIL invariant scen/cycle %0d: got %b expected one-hot status and ordered releases",
                         t, act);
            end
        end
    end

    initial begin
        logic rs, st;
        logic [1:0] al;
        logic [8:0] e;

        step(1'b1, 1'b0, 2'b00, P_IDLE, 0);

        // Nominal bring-up, all links alive.
        for (int c = 0; c <= 34; c++) begin
            step(c == 34, c == 0, 2'b11, phase(c, 0, 30), 1000 + c);
        end

        // One link late to report alive.
        for (int c = 0; c <= 44; c++) begin
            al = (c <= 40) ? 2'b01 : 2'b11;
            step(c == 44, c == 0, al, phase(c, 0, 42), 2000 + c);
        end

        // Reset mid-sequence, then restart.
        for (int c = 0; c <= 31; c++) begin
            rs = (c == 15) || (c == 31);
            st = (c == 0) || (c == 20);
            e  = (c <= 15) ? phase(c, 0, NEVER) : (c < 20) ? P_IDLE : phase(c, 20, NEVER);
            step(rs, st, 2'b11, e, 3000 + c);
        end

        // start while busy is ignored; start in S_DONE re-sequences.
        for (int c = 0; c <= 66; c++) begin
            st = (c == 0) || (c == 3) || (c == 10) || (c == 33);
            e  = (c <= 32) ? phase(c, 0, 30) : (c == 33) ? P_DONE : phase(c, 33, 63);
            step(c == 66, st, 2'b11, e, 4000 + c);
        end

        // Alive never complete: timeout to S_ERROR, or an indefinite wait.
        for (int c = 0; c <= 66; c++) begin
`ifdef BSG_CHIP_LINK_SEQ_TIMEOUT_EN
            e = (c <= 60) ? phase(c, 0, NEVER) : (c <= 63) ? P_ERR : phase(c, 63, NEVER);
`else
            e = phase(c, 0, NEVER);
`endif
            step(c == 66, (c == 0) || (c == 63), 2'b10, e, 5000 + c);
        end

        // reset_i and start_i together: reset wins, both from idle and mid-sequence.
        step(1'b1, 1'b1, 2'b11, P_IDLE, 6000);
        step(1'b0, 1'b1, 2'b11, P_IDLE, 6001);
        step(1'b0, 1'b0, 2'b11, P_HOLD, 6002);
        step(1'b1, 1'b1, 2'b11, P_HOLD, 6003);
        step(1'b0, 1'b0, 2'b11, P_IDLE, 6004);
        step(1'b0, 1'b0, 2'b11, P_IDLE, 6005);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
